bin_sub_const_mod: RTL and testbench
====================================

BIN_SUB_CONST_MOD -- requirements
Module: bin_sub_const_mod

Interface
REQ-001 Parameter OPA_WIDTH, default 18, width of operand and result.
REQ-002 Parameter CONST, default 0, constant subtracted from each operand.
REQ-003 Parameter MODULUS, default 262139, modulus of the residue channel.
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_a  input  OPA_WIDTH  operand, valid when in_valid=1.
REQ-007 Port in_valid  input  1  operand offered.
REQ-008 Port in_ready  output  1  block accepts operand this cycle.
REQ-009 Port out_data  output  OPA_WIDTH  (in_a - CONST) mod MODULUS.
REQ-010 Port out_borrow  output  1  modular wrap applied (in_a < CONST).
REQ-011 Port out_err  output  1  operand out of range (in_a >= MODULUS).
REQ-012 Port out_valid  output  1  result presented.
REQ-013 Port out_ready  input  1  downstream accepts result this cycle.

Function
REQ-014 The block SHALL reject at elaboration any CONST >= MODULUS or MODULUS > 2**OPA_WIDTH.
REQ-015 Transfer in SHALL occur on a posedge with in_valid=1 and in_ready=1; transfer out on a posedge with out_valid=1 and out_ready=1.
REQ-016 Stage 1 SHALL register diff = {1'b0,in_a} - CONST (OPA_WIDTH+1 bits), borrow = diff MSB, err = (in_a >= MODULUS).
REQ-017 Stage 2 SHALL register out_data = borrow ? diff[OPA_WIDTH-1:0] + MODULUS : diff[OPA_WIDTH-1:0], truncated to OPA_WIDTH, plus borrow and err.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 result/cycle.
REQ-019 Each stage SHALL load when it is empty or its contents move downstream in the same cycle; otherwise it SHALL hold.
REQ-020 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle (combinational from out_ready through stage 2 state).
REQ-021 While out_valid=1 and out_ready=0, out_data, out_borrow, out_err SHALL remain stable.
REQ-022 With both stages full and out_ready=0, in_ready SHALL be 0 and no operand is lost or duplicated.
REQ-023 Simultaneous output transfer and input transfer with both stages full SHALL shift the pipeline without a bubble.
REQ-024 Results SHALL leave in acceptance order.
REQ-025 in_a = CONST SHALL yield out_data=0, out_borrow=0; CONST=0 SHALL yield out_data=in_a, out_borrow=0 always.
REQ-026 Out-of-range operands SHALL still be processed per REQ-016/017 with out_err=1; result value is then don't-care for checking.
REQ-027 in_a and in_valid SHALL be ignored while in_ready=0.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear both stage valid bits, out_valid=0, out_data=0, out_borrow=0, out_err=0.
REQ-029 in_ready SHALL be 1 while reset_n=0 is deasserted state is empty (i.e., 1 in the first cycle after reset release).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operands; none SHALL appear after release.

Verification
REQ-031 CONST=5, MODULUS=262139: in_a=10, 3, 5 on consecutive cycles, out_ready=1 -> out_data 5/b0, 262137/b1, 0/b0 at cycles +2,+3,+4.
REQ-032 in_a=262139 (CONST=5) -> out_err=1 two cycles later; in_a=262138 -> out_data=262133, out_err=0.
REQ-033 out_ready=0 for 4 cycles while in_valid=1 with values 1,2,3 -> in_ready drops after 2 accepted, out_data holds 262135; on release outputs 262135, 262136, 262137 in order, no gaps.
REQ-034 Random in_valid/out_ready toggling, 10k operands in [0,MODULUS) -> every output matches reference model (a-CONST) mod MODULUS in order, count equal.
REQ-035 Assert reset_n=0 with 2 operands in flight -> out_valid=0 immediately (asynchronous); after release no stale result; next operand in_a=7 -> out_data=2 after 2 cycles.
REQ-036 CONST=0 build: in_a=0 and 262138 -> out_data identical, out_borrow=0.

Source files
------------

// File: rtl/bin_sub_const_mod.sv
// Two-stage modular subtract-constant pipeline: (in_a - CONST) mod MODULUS
// with valid/ready handshaking on both sides and an out-of-range flag.
module bin_sub_const_mod #(
    parameter int unsigned OPA_WIDTH = 18,
    parameter int unsigned CONST     = 0,
    parameter int unsigned MODULUS   = 262139
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OPA_WIDTH-1:0] in_a,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OPA_WIDTH-1:0] out_data,
    output logic                 out_borrow,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [OPA_WIDTH:0]   CONST_EXT = (OPA_WIDTH+1)'(CONST);
    localparam logic [OPA_WIDTH:0]   MOD_EXT   = (OPA_WIDTH+1)'(MODULUS);
    localparam logic [OPA_WIDTH-1:0] MOD_TRNC  = OPA_WIDTH'(MODULUS);

    if ((CONST >= MODULUS) || (64'(MODULUS) > (64'd1 << OPA_WIDTH))) begin : g_param_check
        $error("bin_sub_const_mod: need CONST < MODULUS <= 2**OPA_WIDTH");
    end

    logic                 s1_valid_q, s1_valid_d;
    logic [OPA_WIDTH:0]   diff_q, diff_d;
    logic                 err1_q, err1_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OPA_WIDTH-1:0] data_q, data_d;
    logic                 borrow_q, borrow_d;
    logic                 err2_q, err2_d;
    logic                 s2_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        diff_d     = diff_q;
        err1_d     = err1_q;
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        borrow_d   = borrow_q;
        err2_d     = err2_q;

        // Stage 2 frees up when empty or draining; stage 1 can then move into it.
        s2_load  = ~s2_valid_q | out_ready;
        in_ready = ~s1_valid_q | s2_load;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_ready && in_valid) begin
            diff_d = {1'b0, in_a} - CONST_EXT;
            err1_d = ({1'b0, in_a} >= MOD_EXT);
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        // Only overwrite result registers with real data so idle outputs stay put.
        if (s2_load && s1_valid_q) begin
            data_d   = diff_q[OPA_WIDTH] ? (diff_q[OPA_WIDTH-1:0] + MOD_TRNC)
                                         : diff_q[OPA_WIDTH-1:0];
            borrow_d = diff_q[OPA_WIDTH];
            err2_d   = err1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            diff_q     <= '0;
            err1_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            borrow_q   <= 1'b0;
            err2_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            diff_q     <= diff_d;
            err1_q     <= err1_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            borrow_q   <= borrow_d;
            err2_q     <= err2_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = data_q;
    assign out_borrow = borrow_q;
    assign out_err    = err2_q;

endmodule

// File: tb/tb_bin_sub_const_mod.sv
// Scoreboard bench: a CONST=5 and a CONST=0 instance share one stimulus stream;
// expected results come from plain modular arithmetic on accepted operands.
module tb_bin_sub_const_mod;

    localparam int unsigned W = 18;
    localparam int unsigned M = 262139;
    localparam int unsigned N_RAND = 10000;

    typedef struct {
        logic [W-1:0] data;
        logic         borrow;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_a;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready5, out_valid5, out_borrow5, out_err5;
    logic [W-1:0] out_data5;
    logic         in_ready0, out_valid0, out_borrow0, out_err0;
    logic [W-1:0] out_data0;

    int passed = 0;
    int total  = 0;

    exp_t q5[$];
    exp_t q0[$];

    bin_sub_const_mod #(.OPA_WIDTH(W), .CONST(5), .MODULUS(M)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_valid(in_valid),
        .in_ready(in_ready5), .out_data(out_data5), .out_borrow(out_borrow5),
        .out_err(out_err5), .out_valid(out_valid5), .out_ready(out_ready)
    );

    bin_sub_const_mod #(.OPA_WIDTH(W), .CONST(0), .MODULUS(M)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_borrow(out_borrow0),
        .out_err(out_err0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned c);
        exp_t e;
        e.err    = (a >= M);
        e.borrow = (a < c);
        e.data   = W'((a + M - c) % M);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: transfers are judged mid-cycle, so they describe the next posedge.
    logic         hold5;
    logic [W-1:0] hold_data5;
    logic         hold_borrow5, hold_err5;

    always @(negedge clk) begin
        if (!reset_n) begin
            hold5 = 1'b0;
        end else begin
            if (hold5) begin
                check("stall_data",   32'(out_data5),   32'(hold_data5));
                check("stall_borrow", 32'(out_borrow5), 32'(hold_borrow5));
                check("stall_err",    32'(out_err5),    32'(hold_err5));
            end
            hold5 = out_valid5 && !out_ready;
            hold_data5 = out_data5; hold_borrow5 = out_borrow5; hold_err5 = out_err5;

            if (in_valid && in_ready5) q5.push_back(model(32'(in_a), 5));
            if (in_valid && in_ready0) q0.push_back(model(32'(in_a), 0));

            if (out_valid5 && out_ready) begin
                if (q5.size() == 0) begin
                    check("dut5_unexpected_output", 32'(out_data5), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q5.pop_front();
                    if (!e.err) check("dut5_data", 32'(out_data5), 32'(e.data));
                    check("dut5_borrow", 32'(out_borrow5), 32'(e.borrow));
                    check("dut5_err",    32'(out_err5),    32'(e.err));
                end
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_output", 32'(out_data0), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    if (!e.err) check("dut0_data", 32'(out_data0), 32'(e.data));
                    check("dut0_borrow", 32'(out_borrow0), 32'(e.borrow));
                    check("dut0_err",    32'(out_err0),    32'(e.err));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int idx;
        int sent;
        int cyc;
        logic [W-1:0] vals [3];

        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
        #2;
        check("rst_out_valid",  32'(out_valid5),  32'd0);
        check("rst_out_data",   32'(out_data5),   32'd0);
        check("rst_out_borrow", 32'(out_borrow5), 32'd0);
        check("rst_out_err",    32'(out_err5),    32'd0);
        check("rst_in_ready",   32'(in_ready5),   32'd1);
        #10 reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready5), 32'd1);

        // Back-to-back 10, 3, 5 with a free-running sink
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = W'(10);
        tick(); in_a = W'(3);
        check("lat_cycle1_valid", 32'(out_valid5), 32'd0);
        tick(); in_a = W'(5);
        check("lat_cycle2_valid", 32'(out_valid5), 32'd1);
        check("seq_10_data",   32'(out_data5),   32'd5);
        check("seq_10_borrow", 32'(out_borrow5), 32'd0);
        tick(); in_valid = 1'b0;
        check("seq_3_data",   32'(out_data5),   32'd262137);
        check("seq_3_borrow", 32'(out_borrow5), 32'd1);
        tick();
        check("seq_5_data",   32'(out_data5),   32'd0);
        check("seq_5_borrow", 32'(out_borrow5), 32'd0);
        check("seq_5_valid",  32'(out_valid5),  32'd1);
        tick();
        check("seq_drained", 32'(out_valid5), 32'd0);

        // Range edges: first operand out of range, second just inside
        in_valid = 1'b1; in_a = W'(262139);
        tick(); in_a = W'(262138);
        tick(); in_valid = 1'b0;
        check("oor_err", 32'(out_err5), 32'd1);
        tick();
        check("edge_data", 32'(out_data5), 32'd262133);
        check("edge_err",  32'(out_err5),  32'd0);
        tick();

        // Zero-constant instance passes operands straight through
        in_valid = 1'b1; in_a = '0;
        tick(); in_a = W'(262138);
        tick(); in_valid = 1'b0;
        check("c0_zero_data",   32'(out_data0),   32'd0);
        check("c0_zero_borrow", 32'(out_borrow0), 32'd0);
        tick();
        check("c0_max_data",   32'(out_data0),   32'd262138);
        check("c0_max_borrow", 32'(out_borrow0), 32'd0);
        tick();

        // Backpressure: sink stalls for 4 cycles while 1,2,3 are offered
        vals[0] = W'(1); vals[1] = W'(2); vals[2] = W'(3);
        out_ready = 1'b0; in_valid = 1'b1; idx = 0; in_a = vals[0];
        for (int i = 0; i < 4; i++) begin
            #1;
            if (in_ready5) idx++;
            tick();
            in_a = vals[idx];
        end
        #1;
        check("bp_accepted",  32'(idx),        32'd2);
        check("bp_in_ready",  32'(in_ready5),  32'd0);
        check("bp_out_valid", 32'(out_valid5), 32'd1);
        check("bp_out_data",  32'(out_data5),  32'd262135);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready5), 32'd1);
        tick(); in_valid = 1'b0;
        check("bp_nogap1_valid", 32'(out_valid5), 32'd1);
        check("bp_nogap1_data",  32'(out_data5),  32'd262136);
        tick();
        check("bp_nogap2_valid", 32'(out_valid5), 32'd1);
        check("bp_nogap2_data",  32'(out_data5),  32'd262137);
        tick();
        check("bp_drained", 32'(out_valid5), 32'd0);

        // Reset with two operands in flight
        out_ready = 1'b0; in_valid = 1'b1; in_a = W'(100);
        tick(); in_a = W'(200);
        tick(); in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid5), 32'd0);
        check("midrst_out_data",  32'(out_data5),  32'd0);
        q5.delete(); q0.delete();
        tick();
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("midrst_no_stale", 32'(out_valid5), 32'd0);
        tick();
        check("midrst_no_stale2", 32'(out_valid5), 32'd0);
        in_valid = 1'b1; in_a = W'(7);
        tick(); in_valid = 1'b0;
        tick();
        check("midrst_next_valid", 32'(out_valid5), 32'd1);
        check("midrst_next_data",  32'(out_data5),  32'd2);
        tick();

        // Randomized traffic with independent source and sink toggling
        sent = 0; cyc = 0;
        while (sent < N_RAND && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            in_a      = W'($urandom_range(0, M - 1));
            #1;
            if (in_valid && in_ready5) sent++;
            tick();
            cyc++;
        end
        check("rand_all_sent", 32'(sent), 32'(N_RAND));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && (q5.size() != 0 || q0.size() != 0); i++) tick();
        tick();
        check("rand_q5_empty", 32'(q5.size()), 32'd0);
        check("rand_q0_empty", 32'(q0.size()), 32'd0);
        check("rand_idle", 32'(out_valid5), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
